// File: rtl/ysyx_24110006_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24110006_wbu
// Brief    : Write-back unit. Registers the LSU result over a valid/ready
//            handshake and commits it one cycle later to the 32x32 GPR file
//            and the 4-entry machine CSR file (mstatus, mtvec, mepc, mcause).
//            Provides combinational GPR/CSR read ports, the pending
//            destination for hazard detection and a retired-instruction count.
// Options  : YSYX_WBU_BYPASS_EN - when defined, reads forward the value being
//            committed in the current cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24110006_wbu (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_reg_rd,
    input  logic        i_reg_wen,
    input  logic [31:0] i_result,
    input  logic        i_csr_wen,
    input  logic [1:0]  i_csr_t,
    input  logic [31:0] i_csr_wdata,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic [1:0]  i_csr_raddr,
    output logic [31:0] o_csr_rdata,
    output logic        o_pend_valid,
    output logic [4:0]  o_pend_rd,
    output logic        o_commit,
    output logic [63:0] o_instret
);

    // mstatus comes out of reset with MPP = machine mode
    localparam logic [31:0] C_MSTATUS_RST = 32'h0000_1800;
    localparam logic [1:0]  C_CSR_MSTATUS = 2'b00;

    // Write-back stage register
    logic        wb_valid_q,     wb_valid_d;
    logic [4:0]  wb_rd_q,        wb_rd_d;
    logic        wb_reg_wen_q,   wb_reg_wen_d;
    logic [31:0] wb_result_q,    wb_result_d;
    logic        wb_csr_wen_q,   wb_csr_wen_d;
    logic [1:0]  wb_csr_t_q,     wb_csr_t_d;
    logic [31:0] wb_csr_wdata_q, wb_csr_wdata_d;

    // Architectural state
    logic [31:0] gpr_q [32];
    logic [31:0] gpr_d [32];
    logic [31:0] csr_q [4];
    logic [31:0] csr_d [4];
    logic [63:0] instret_q, instret_d;

    logic        w_accept;
    logic        w_pend_valid;

    // The WBU never back-pressures; it is only unavailable during reset
    assign o_ready  = !i_reset;
    assign w_accept = i_valid && o_ready;

    // Capture the LSU result; fields hold when idle, valid lasts one cycle
    always_comb begin
        wb_valid_d     = w_accept;
        wb_rd_d        = wb_rd_q;
        wb_reg_wen_d   = wb_reg_wen_q;
        wb_result_d    = wb_result_q;
        wb_csr_wen_d   = wb_csr_wen_q;
        wb_csr_t_d     = wb_csr_t_q;
        wb_csr_wdata_d = wb_csr_wdata_q;
        if (w_accept) begin
            wb_rd_d        = i_reg_rd;
            wb_reg_wen_d   = i_reg_wen;
            wb_result_d    = i_result;
            wb_csr_wen_d   = i_csr_wen;
            wb_csr_t_d     = i_csr_t;
            wb_csr_wdata_d = i_csr_wdata;
        end
    end

    // Pending GPR write: x0 destinations never count as a hazard
    assign w_pend_valid = wb_valid_q && wb_reg_wen_q && (wb_rd_q != 5'd0);
    assign o_pend_valid = w_pend_valid;
    assign o_pend_rd    = w_pend_valid ? wb_rd_q : 5'd0;
    assign o_commit     = wb_valid_q;
    assign o_instret    = instret_q;

    // Commit: GPR and CSR writes may both happen in the same cycle
    always_comb begin
        gpr_d     = gpr_q;
        csr_d     = csr_q;
        instret_d = instret_q;
        if (w_pend_valid) begin
            gpr_d[wb_rd_q] = wb_result_q;
        end
        if (wb_valid_q && wb_csr_wen_q) begin
            csr_d[wb_csr_t_q] = wb_csr_wdata_q;
        end
        if (wb_valid_q) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Combinational read ports; x0 is hardwired to zero
    always_comb begin
        o_rs1_data  = (i_rs1 == 5'd0) ? 32'd0 : gpr_q[i_rs1];
        o_rs2_data  = (i_rs2 == 5'd0) ? 32'd0 : gpr_q[i_rs2];
        o_csr_rdata = csr_q[i_csr_raddr];
`ifdef YSYX_WBU_BYPASS_EN
        // Forward the value being committed so decode need not stall
        if (w_pend_valid && (wb_rd_q == i_rs1)) begin
            o_rs1_data = wb_result_q;
        end
        if (w_pend_valid && (wb_rd_q == i_rs2)) begin
            o_rs2_data = wb_result_q;
        end
        if (wb_valid_q && wb_csr_wen_q && (wb_csr_t_q == i_csr_raddr)) begin
            o_csr_rdata = wb_csr_wdata_q;
        end
`else
        // No forwarding: decode stalls on o_pend_valid/o_pend_rd instead
`endif
    end

    // State update; reset discards any pending commit
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_reg_wen_q   <= 1'b0;
            wb_result_q    <= 32'd0;
            wb_csr_wen_q   <= 1'b0;
            wb_csr_t_q     <= 2'd0;
            wb_csr_wdata_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 32'd0;
            end
            for (int j = 0; j < 4; j++) begin
                csr_q[j] <= 32'd0;
            end
            csr_q[C_CSR_MSTATUS] <= C_MSTATUS_RST;
            instret_q      <= 64'd0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_wen_q   <= wb_reg_wen_d;
            wb_result_q    <= wb_result_d;
            wb_csr_wen_q   <= wb_csr_wen_d;
            wb_csr_t_q     <= wb_csr_t_d;
            wb_csr_wdata_q <= wb_csr_wdata_d;
            gpr_q          <= gpr_d;
            csr_q          <= csr_d;
            instret_q      <= instret_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24110006_wbu.md
# ysyx_24110006_wbu

Write-back unit sitting directly downstream of the load/store stage. Captures the committed result, destination register, and CSR target from the LSU over a valid/ready handshake, then writes the integrated 32x32 GPR file and the 4-entry machine CSR file one cycle later. Serves combinational GPR/CSR read ports to decode, exposes the pending destination for hazard detection, and counts retired instructions.

## Interface
- No parameters.
- i_clock  in  1  core clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  LSU result valid
- o_ready  out  1  WBU can accept; `!i_reset`
- i_reg_rd  in  5  GPR destination index
- i_reg_wen  in  1  GPR write enable
- i_result  in  32  GPR write data (LSU o_result)
- i_csr_wen  in  1  CSR write enable
- i_csr_t  in  2  CSR target: 00 mstatus, 01 mtvec, 10 mepc, 11 mcause
- i_csr_wdata  in  32  CSR write data
- i_rs1 / i_rs2  in  5 each  GPR read indices
- o_rs1_data / o_rs2_data  out  32 each  GPR read data; x0 reads 0
- i_csr_raddr  in  2  CSR read select (same encoding as i_csr_t)
- o_csr_rdata  out  32  CSR read data
- o_pend_valid  out  1  a GPR write to a nonzero rd is pending this cycle
- o_pend_rd  out  5  pending GPR index
- o_commit  out  1  one-cycle pulse per retired instruction
- o_instret  out  64  retired-instruction count

## Operation
- Capture: when `i_valid && o_ready`, latch rd, reg_wen, result, csr_wen, csr_t, csr_wdata into the WB register; wb_valid <= 1. With no accept, wb_valid <= 0. Back-to-back accepts give one commit per cycle.
- Commit: in any cycle where wb_valid = 1:
  - GPR[rd] <= result if reg_wen and rd != 0.
  - CSR[csr_t] <= csr_wdata if csr_wen.
  - o_commit = 1.
  - o_instret increments by 1, wrapping from 2^64-1 to 0.
- A GPR write and a CSR write in the same commit are both performed.
- x0: writes are dropped; reads always return 0.
- Pending: `o_pend_valid = wb_valid && reg_wen && rd != 0`, and `o_pend_rd = rd`. When o_pend_valid = 0, o_pend_rd is 0.
- Reads are combinational from array state. Bypass behaviour is set by the macro; see Configuration.

## Timing
- Reset values (asynchronous; held while i_reset = 1):
  - wb_valid 0; o_commit 0; o_pend_valid 0; o_pend_rd 0; o_instret 0.
  - All GPRs 0.
  - mstatus 32'h0000_1800; mtvec, mepc, mcause 0.
  - o_ready 0.
- Latency: an accept at edge N makes the write visible in the arrays after edge N+1. o_commit is high during cycle N→N+1.
- Reset asserted mid-operation discards a pending commit; no array write happens.
- Handshake: the LSU holds i_valid for exactly one cycle per result. The WBU never back-pressures outside reset.

## Configuration
- YSYX_WBU_BYPASS_EN defined:
  - Any GPR read port whose index equals a pending nonzero rd with reg_wen returns the pending result in the commit cycle.
  - o_csr_rdata returns csr_wdata when csr_wen and csr_raddr == csr_t in the commit cycle.
- Undefined: reads return array contents only. The new value appears the cycle after commit, and decode must stall on o_pend_valid/o_pend_rd.

## Test plan
- Reset: assert i_reset asynchronously mid-cycle → all outputs at reset values immediately; CSR read 2'b00 returns 32'h0000_1800; o_instret = 0.
- Basic write: accept rd = 5, reg_wen = 1, result = 32'hDEAD_BEEF → o_commit pulses one cycle later, o_pend_rd = 5 in that cycle; the following cycle o_rs1_data = 32'hDEAD_BEEF with i_rs1 = 5.
- x0 guard: accept rd = 0, reg_wen = 1, result = 32'h1234 → o_pend_valid = 0, i_rs2 = 0 reads 0, o_instret still increments.
- CSR + GPR in one commit: rd = 3, result = 7, csr_wen = 1, csr_t = 2'b10, csr_wdata = 32'h8000_0100 → x3 = 7 and mepc = 32'h8000_0100 after commit.
- Bypass: in the commit cycle of rd = 9, result = 42, drive i_rs1 = 9 → returns 42 with YSYX_WBU_BYPASS_EN defined, old value (0) without it.
- Back-to-back and wrap: 4 consecutive accepts → 4 consecutive o_commit pulses, o_instret += 4. Force o_instret to 2^64-1 via a hierarchical deposit, then commit once → o_instret reads 0.
